lcd_char_responder: RTL and testbench
=====================================

// Module: lcd_char_responder
// PURPOSE
//  Receiving end of the HD44780-style character-LCD bus driven by our LCD controllers (E/RS/RW/DATA[7:0]).
//  Decodes instruction and data writes into a 2x16 display RAM.
//  Exposes display state to the bench and scoreboards, replacing the physical panel in simulation and on-board self-check.
//  Runs on its own faster clock; LCD_E is a sampled input, not a clock.
// PARAMETERS
//  BUSY_CYCLES  4   CLK cycles BUSY stays high after an ordinary command or data write
//  CLR_CYCLES   64  CLK cycles BUSY stays high after clear-display / return-home
// PORTS
//  CLK           in   1  responder clock; at least 4x the LCD_E toggle rate
//  RESETN        in   1  asynchronous, active-low reset
//  LCD_E         in   1  bus enable; transfer is accepted on its falling edge
//  LCD_RS        in   1  0 = instruction, 1 = data
//  LCD_RW        in   1  0 = write, 1 = read
//  LCD_DATA      in   8  bus data
//  RD_ROW        in   1  inspection row
//  RD_COL        in   4  inspection column
//  RD_CHAR       out  8  registered DDRAM[RD_ROW,RD_COL]; 0x20 while DISP_ON=0
//  CURSOR_ADDR   out  7  address counter AC in HD44780 form (0x00-0x0F, 0x40-0x4F)
//  DISP_ON       out  1  display-on bit
//  TWO_LINE      out  1  N bit from function set
//  BUSY          out  1  command executing
//  CMD_VALID     out  1  one-cycle pulse per accepted write
//  ERR_BUSY_WR   out  1  sticky: a transfer arrived while BUSY
//  LCD_DQ_OUT    out  8  read-back data (readback feature)
//  LCD_DQ_OE     out  1  read-back drive enable (readback feature)
// BEHAVIOUR
//  Reset values:
//   - all outputs 0, except RD_CHAR = 0x20
//   - DDRAM (32x8 register array) all 0x20
//   - AC = 0, I/D = 1
//  Input capture:
//   - E, RS, RW, DATA pass through a 2-flop synchroniser/pipeline together.
//   - Falling edge = sync E goes 1 -> 0; RS/RW/DATA are sampled in that same cycle.
//  FSM states: IDLE -> EXEC -> BUSY -> IDLE.
//   - IDLE: a falling edge moves to EXEC.
//   - EXEC: one cycle; performs the write and pulses CMD_VALID.
//   - BUSY: counts BUSY_CYCLES or CLR_CYCLES, then returns to IDLE.
//  Transfers arriving in EXEC or BUSY:
//   - discarded
//   - set ERR_BUSY_WR, which clears only on reset
//  Instruction decode (RS=0, RW=0), highest set bit wins:
//   - 1aaaaaaa  set AC = {a[6], a[3:0]}; a[5:4] ignored
//   - 01xxxxxx  CGRAM address: no effect, normal busy
//   - 001xNxxx  TWO_LINE = N
//   - 0001SRxx  S=0: AC moves +1 (R=1) or -1 (R=0); S=1 ignored
//   - 00001Dxx  DISP_ON = D
//   - 000001Ix  I/D = I
//   - 0000001x  AC = 0; busy CLR_CYCLES
//   - 00000001  all DDRAM = 0x20, AC = 0, I/D = 1; busy CLR_CYCLES
//   - 00000000  no-op, normal busy
//  Data write (RS=1, RW=0): DDRAM[AC] = DATA, then AC steps per I/D.
//  AC wrap:
//   - increment: 0x0F -> 0x40, 0x4F -> 0x00
//   - decrement: 0x00 -> 0x4F, 0x40 -> 0x0F
//  RD_CHAR has 1-cycle latency from RD_ROW/RD_COL.
//  Reset asserted mid-BUSY aborts the command immediately; every output returns to its reset value.
// CONFIGURATION
//  LCD_READBACK_EN defined:
//   - While sync E=1 and RW=1, LCD_DQ_OE=1.
//   - RS=0: LCD_DQ_OUT = {BUSY, CURSOR_ADDR}.
//   - RS=1: LCD_DQ_OUT = DDRAM[AC]; on the E falling edge AC steps per I/D, with normal busy.
//  LCD_READBACK_EN undefined:
//   - Reads are ignored: no busy, no error.
//   - LCD_DQ_OUT = 0 and LCD_DQ_OE = 0 constantly.
// STRUCTURE
//  Package lcd_resp_pkg:
//   - FSM state enum
//   - opcode mask constants
//   - ASCII_SPACE = 8'h20
//   - LINE2_BASE = 7'h40
//  Sub-module lcd_bus_sync: 2-flop input pipeline plus E falling-edge detect, output fall_stb.
// TESTING
//  T1 init: write 0x3C, 0x0C, 0x06
//     -> TWO_LINE=1, DISP_ON=1, BUSY high 4 cycles after each, ERR_BUSY_WR=0
//  T2 text: 0x80, data 0x53, 0x74
//     -> RD(0,0)=0x53, RD(0,1)=0x74, CURSOR_ADDR=0x02, two CMD_VALID pulses
//  T3 wrap: 0x8F, data 0x41, 0x42
//     -> RD(0,15)=0x41, RD(1,0)=0x42, CURSOR_ADDR=0x41
//  T4 decrement: 0x04, 0xC0, data 0x5A
//     -> RD(1,0)=0x5A, CURSOR_ADDR=0x0F
//  T5 clear: 0x01, then a data write 10 cycles later
//     -> all RD=0x20, AC=0, BUSY 64 cycles, write dropped, ERR_BUSY_WR=1
//  T6 RESETN low mid-BUSY -> BUSY=0, DISP_ON=0, all RD=0x20
//     with LCD_READBACK_EN: RS=0/RW=1 read -> LCD_DQ_OUT={0, AC}

Source files
------------

// File: rtl/lcd_resp_pkg.sv
// lcd_resp_pkg
//   Shared types and constants for the HD44780-style bus responder.
//   - lcd_state_e : command FSM states (IDLE -> EXEC -> BUSY -> IDLE)
//   - OP_*        : one-hot opcode masks, decoded highest-set-bit first
//   - *_BIT       : argument bit positions inside the instruction byte
//   - ac_step     : address-counter step with the two-line wrap rules
//   - ac_to_addr  : compact {row, col} counter to HD44780 DDRAM address
package lcd_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_BUSY = 2'b10
    } lcd_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [6:0] LINE2_BASE  = 7'h40;

    localparam logic [7:0] OP_SET_DDRAM   = 8'h80;
    localparam logic [7:0] OP_SET_CGRAM   = 8'h40;
    localparam logic [7:0] OP_FUNC_SET    = 8'h20;
    localparam logic [7:0] OP_SHIFT       = 8'h10;
    localparam logic [7:0] OP_DISP_CTRL   = 8'h08;
    localparam logic [7:0] OP_ENTRY_MODE  = 8'h04;
    localparam logic [7:0] OP_RETURN_HOME = 8'h02;
    localparam logic [7:0] OP_CLEAR       = 8'h01;

    localparam int unsigned FUNC_N_BIT   = 3;
    localparam int unsigned SHIFT_S_BIT  = 3;
    localparam int unsigned SHIFT_R_BIT  = 2;
    localparam int unsigned DISP_D_BIT   = 2;
    localparam int unsigned ENTRY_ID_BIT = 1;

    // The counter is kept as {row, col}; stepping past either end of a
    // line moves to the other line, which gives 0x0F->0x40, 0x4F->0x00
    // on increment and 0x00->0x4F, 0x40->0x0F on decrement.
    function automatic logic [4:0] ac_step(input logic [4:0] ac, input logic inc);
        logic [4:0] r;
        r = ac;
        if (inc) begin
            if (ac[3:0] == 4'hF) r = {~ac[4], 4'h0};
            else                 r = {ac[4], ac[3:0] + 4'h1};
        end else begin
            if (ac[3:0] == 4'h0) r = {~ac[4], 4'hF};
            else                 r = {ac[4], ac[3:0] - 4'h1};
        end
        return r;
    endfunction

    function automatic logic [6:0] ac_to_addr(input logic [4:0] ac);
        logic [6:0] a;
        a = {3'b000, ac[3:0]};
        if (ac[4]) a = LINE2_BASE | a;
        return a;
    endfunction

endpackage

// File: rtl/lcd_char_responder_sync.sv
// lcd_bus_sync
//   Two-flop synchroniser for the asynchronous LCD bus (E, RS, RW, DATA
//   travel together) plus falling-edge detect on the synchronised E.
//   Ports:
//     clk_i, rst_ni        responder clock, async active-low reset
//     e_i/rs_i/rw_i/data_i raw LCD bus
//     rs_o/rw_o/data_o     synchronised bus, valid in the fall_stb_o cycle
//     fall_stb_o           one-cycle strobe when synchronised E goes 1->0
//     rd_drive_o           synchronised E=1 and RW=1 (forced 0 if RD_EN=0)
module lcd_bus_sync #(
    parameter bit RD_EN = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       e_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [7:0] data_i,
    output logic       rs_o,
    output logic       rw_o,
    output logic [7:0] data_o,
    output logic       fall_stb_o,
    output logic       rd_drive_o
);

    // Packed as {e, rs, rw, data[7:0]}
    logic [10:0] stg1_q;
    logic [10:0] stg2_q;
    logic        e_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stg1_q   <= '0;
            stg2_q   <= '0;
            e_prev_q <= 1'b0;
        end else begin
            stg1_q   <= {e_i, rs_i, rw_i, data_i};
            stg2_q   <= stg1_q;
            e_prev_q <= stg2_q[10];
        end
    end

    assign rs_o       = stg2_q[9];
    assign rw_o       = stg2_q[8];
    assign data_o     = stg2_q[7:0];
    assign fall_stb_o = e_prev_q & ~stg2_q[10];
    assign rd_drive_o = RD_EN & stg2_q[10] & stg2_q[8];

endmodule

// File: rtl/lcd_char_responder.sv
// lcd_char_responder
//   Receiving end of an HD44780-style character LCD bus. Decodes
//   instruction and data writes into a 2x16 DDRAM and exposes the display
//   state for inspection. LCD_E is sampled on CLK, never used as a clock.
//   Optional feature macro: LCD_READBACK_EN (bus reads of busy/AC and
//   DDRAM). Without it reads are ignored and LCD_DQ_* are held at 0.
//   Ports:
//     CLK, RESETN          responder clock, async active-low reset
//     LCD_E/RS/RW/DATA     LCD bus inputs; transfer taken on E falling edge
//     RD_ROW, RD_COL       inspection address
//     RD_CHAR              registered DDRAM[RD_ROW,RD_COL], 0x20 if display off
//     CURSOR_ADDR          address counter in HD44780 form
//     DISP_ON, TWO_LINE    display-on and function-set N bits
//     BUSY                 command executing
//     CMD_VALID            one-cycle pulse per accepted write
//     ERR_BUSY_WR          sticky: transfer arrived while not idle
//     LCD_DQ_OUT/LCD_DQ_OE read-back data and drive enable
module lcd_char_responder
    import lcd_resp_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = 4,
    parameter int unsigned CLR_CYCLES  = 64
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic [7:0] LCD_DATA,
    input  logic       RD_ROW,
    input  logic [3:0] RD_COL,
    output logic [7:0] RD_CHAR,
    output logic [6:0] CURSOR_ADDR,
    output logic       DISP_ON,
    output logic       TWO_LINE,
    output logic       BUSY,
    output logic       CMD_VALID,
    output logic       ERR_BUSY_WR,
    output logic [7:0] LCD_DQ_OUT,
    output logic       LCD_DQ_OE
);

`ifdef LCD_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    localparam int unsigned CNT_MAX = (CLR_CYCLES > BUSY_CYCLES) ? CLR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Synchronised bus
    logic       rs_s;
    logic       rw_s;
    logic [7:0] data_s;
    logic       fall_stb;
    logic       rd_drive;

    lcd_bus_sync #(
        .RD_EN (READBACK)
    ) u_sync (
        .clk_i      (CLK),
        .rst_ni     (RESETN),
        .e_i        (LCD_E),
        .rs_i       (LCD_RS),
        .rw_i       (LCD_RW),
        .data_i     (LCD_DATA),
        .rs_o       (rs_s),
        .rw_o       (rw_s),
        .data_o     (data_s),
        .fall_stb_o (fall_stb),
        .rd_drive_o (rd_drive)
    );

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_rs_q, cmd_rs_d;
    logic             cmd_rw_q, cmd_rw_d;
    logic [7:0]       cmd_data_q, cmd_data_d;
    logic [4:0]       ac_q, ac_d;          // {row, col}
    logic             id_q, id_d;
    logic             disp_on_q, disp_on_d;
    logic             two_line_q, two_line_d;
    logic             err_q, err_d;
    logic [7:0]       rd_char_q;
    logic [7:0]       ddram_q [32];

    logic             ddram_we;
    logic             ddram_clr;
    logic             long_busy;
    logic             xfer_ok;

    // Transfers that the responder acts on; anything else is invisible
    // (no busy, no error). With read-back only data reads advance AC.
`ifdef LCD_READBACK_EN
    assign xfer_ok = !rw_s || rs_s;
`else
    assign xfer_ok = !rw_s;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_rs_d   = cmd_rs_q;
        cmd_rw_d   = cmd_rw_q;
        cmd_data_d = cmd_data_q;
        ac_d       = ac_q;
        id_d       = id_q;
        disp_on_d  = disp_on_q;
        two_line_d = two_line_q;
        err_d      = err_q;
        ddram_we   = 1'b0;
        ddram_clr  = 1'b0;
        long_busy  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (fall_stb && xfer_ok) begin
                    cmd_rs_d   = rs_s;
                    cmd_rw_d   = rw_s;
                    cmd_data_d = data_s;
                    state_d    = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_BUSY;
                if (cmd_rw_q) begin
                    ac_d = ac_step(ac_q, id_q);
                end else if (cmd_rs_q) begin
                    ddram_we = 1'b1;
                    ac_d     = ac_step(ac_q, id_q);
                end else if ((cmd_data_q & OP_SET_DDRAM) != 8'h00) begin
                    ac_d = {cmd_data_q[6], cmd_data_q[3:0]};
                end else if ((cmd_data_q & OP_SET_CGRAM) != 8'h00) begin
                    // CGRAM is not modelled; only the busy time applies
                    ac_d = ac_q;
                end else if ((cmd_data_q & OP_FUNC_SET) != 8'h00) begin
                    two_line_d = cmd_data_q[FUNC_N_BIT];
                end else if ((cmd_data_q & OP_SHIFT) != 8'h00) begin
                    if (!cmd_data_q[SHIFT_S_BIT]) begin
                        ac_d = ac_step(ac_q, cmd_data_q[SHIFT_R_BIT]);
                    end
                end else if ((cmd_data_q & OP_DISP_CTRL) != 8'h00) begin
                    disp_on_d = cmd_data_q[DISP_D_BIT];
                end else if ((cmd_data_q & OP_ENTRY_MODE) != 8'h00) begin
                    id_d = cmd_data_q[ENTRY_ID_BIT];
                end else if ((cmd_data_q & OP_RETURN_HOME) != 8'h00) begin
                    ac_d      = '0;
                    long_busy = 1'b1;
                end else if ((cmd_data_q & OP_CLEAR) != 8'h00) begin
                    ddram_clr = 1'b1;
                    ac_d      = '0;
                    id_d      = 1'b1;
                    long_busy = 1'b1;
                end
                // Counter is loaded with N-1 so BUSY is high for exactly N cycles
                cnt_d = long_busy ? CNT_W'(CLR_CYCLES - 1) : CNT_W'(BUSY_CYCLES - 1);
            end

            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end

            default: state_d = ST_IDLE;
        endcase

        if (fall_stb && xfer_ok && (state_q != ST_IDLE)) err_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_rs_q   <= 1'b0;
            cmd_rw_q   <= 1'b0;
            cmd_data_q <= '0;
            ac_q       <= '0;
            id_q       <= 1'b1;
            disp_on_q  <= 1'b0;
            two_line_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_rs_q   <= cmd_rs_d;
            cmd_rw_q   <= cmd_rw_d;
            cmd_data_q <= cmd_data_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            disp_on_q  <= disp_on_d;
            two_line_q <= two_line_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int unsigned i = 0; i < 32; i++) ddram_q[i] <= ASCII_SPACE;
        end else if (ddram_clr) begin
            for (int unsigned i = 0; i < 32; i++) ddram_q[i] <= ASCII_SPACE;
        end else if (ddram_we) begin
            ddram_q[ac_q] <= cmd_data_q;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) rd_char_q <= ASCII_SPACE;
        else         rd_char_q <= disp_on_q ? ddram_q[{RD_ROW, RD_COL}] : ASCII_SPACE;
    end

    assign RD_CHAR     = rd_char_q;
    assign CURSOR_ADDR = ac_to_addr(ac_q);
    assign DISP_ON     = disp_on_q;
    assign TWO_LINE    = two_line_q;
    assign BUSY        = (state_q == ST_BUSY);
    assign CMD_VALID   = (state_q == ST_EXEC) && !cmd_rw_q;
    assign ERR_BUSY_WR = err_q;
    assign LCD_DQ_OE   = rd_drive;

`ifdef LCD_READBACK_EN
    assign LCD_DQ_OUT = rs_s ? ddram_q[ac_q] : {BUSY, CURSOR_ADDR};
`else
    assign LCD_DQ_OUT = '0;
`endif

endmodule

// File: tb/tb_lcd_char_responder.sv
// tb_lcd_char_responder
//   Directed checks of lcd_char_responder with hand-computed expectations.
module tb_lcd_char_responder;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       LCD_E = 1'b0;
    logic       LCD_RS = 1'b0;
    logic       LCD_RW = 1'b0;
    logic [7:0] LCD_DATA = 8'h00;
    logic       RD_ROW = 1'b0;
    logic [3:0] RD_COL = 4'h0;
    logic [7:0] RD_CHAR;
    logic [6:0] CURSOR_ADDR;
    logic       DISP_ON;
    logic       TWO_LINE;
    logic       BUSY;
    logic       CMD_VALID;
    logic       ERR_BUSY_WR;
    logic [7:0] LCD_DQ_OUT;
    logic       LCD_DQ_OE;

    int checks = 0;
    int errors = 0;
    int busy_total = 0;
    int cv_total = 0;

    lcd_char_responder #(
        .BUSY_CYCLES (4),
        .CLR_CYCLES  (64)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .LCD_E       (LCD_E),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_DATA    (LCD_DATA),
        .RD_ROW      (RD_ROW),
        .RD_COL      (RD_COL),
        .RD_CHAR     (RD_CHAR),
        .CURSOR_ADDR (CURSOR_ADDR),
        .DISP_ON     (DISP_ON),
        .TWO_LINE    (TWO_LINE),
        .BUSY        (BUSY),
        .CMD_VALID   (CMD_VALID),
        .ERR_BUSY_WR (ERR_BUSY_WR),
        .LCD_DQ_OUT  (LCD_DQ_OUT),
        .LCD_DQ_OE   (LCD_DQ_OE)
    );

    always #5 CLK = ~CLK;

    // Running tallies of BUSY-high cycles and CMD_VALID pulses
    always @(negedge CLK) begin
        if (BUSY) busy_total++;
        if (CMD_VALID) cv_total++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic pulse_e(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge CLK);
        LCD_RS = rs; LCD_RW = rw; LCD_DATA = d; LCD_E = 1'b1;
        repeat (4) @(negedge CLK);
        LCD_E = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wr_cmd(input logic [7:0] d);
        pulse_e(1'b0, 1'b0, d);
        repeat (20) @(negedge CLK);
    endtask

    task automatic wr_dat(input logic [7:0] d);
        pulse_e(1'b1, 1'b0, d);
        repeat (20) @(negedge CLK);
    endtask

    task automatic rd_check(input string tag, input logic row, input logic [3:0] col, input logic [7:0] exp);
        @(negedge CLK);
        RD_ROW = row; RD_COL = col;
        @(negedge CLK);
        check(tag, {24'h0, RD_CHAR}, {24'h0, exp});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int b0;
        int c0;
        logic [7:0] init_cmds [3];
        init_cmds[0] = 8'h3C; init_cmds[1] = 8'h0C; init_cmds[2] = 8'h06;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_rd_char", {24'h0, RD_CHAR}, 32'h20);
        check("rst_cursor", {25'h0, CURSOR_ADDR}, 32'h0);
        check("rst_disp_on", {31'h0, DISP_ON}, 32'h0);
        check("rst_two_line", {31'h0, TWO_LINE}, 32'h0);
        check("rst_busy", {31'h0, BUSY}, 32'h0);
        check("rst_cmd_valid", {31'h0, CMD_VALID}, 32'h0);
        check("rst_err", {31'h0, ERR_BUSY_WR}, 32'h0);
        check("rst_dq_oe", {31'h0, LCD_DQ_OE}, 32'h0);
        check("rst_dq_out", {24'h0, LCD_DQ_OUT}, 32'h0);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);

        // T1 init
        for (int i = 0; i < 3; i++) begin
            b0 = busy_total; c0 = cv_total;
            wr_cmd(init_cmds[i]);
            check("t1_busy_len", busy_total - b0, 4);
            check("t1_cmd_valid", cv_total - c0, 1);
        end
        check("t1_two_line", {31'h0, TWO_LINE}, 32'h1);
        check("t1_disp_on", {31'h0, DISP_ON}, 32'h1);
        check("t1_err", {31'h0, ERR_BUSY_WR}, 32'h0);

        // T2 text
        wr_cmd(8'h80);
        c0 = cv_total;
        wr_dat(8'h53);
        wr_dat(8'h74);
        check("t2_cmd_valid", cv_total - c0, 2);
        rd_check("t2_rd00", 1'b0, 4'd0, 8'h53);
        rd_check("t2_rd01", 1'b0, 4'd1, 8'h74);
        check("t2_cursor", {25'h0, CURSOR_ADDR}, 32'h02);

        // T3 line wrap on increment
        wr_cmd(8'h8F);
        wr_dat(8'h41);
        wr_dat(8'h42);
        rd_check("t3_rd0f", 1'b0, 4'd15, 8'h41);
        rd_check("t3_rd10", 1'b1, 4'd0, 8'h42);
        check("t3_cursor", {25'h0, CURSOR_ADDR}, 32'h41);

        // T4 decrement across line 2 start
        wr_cmd(8'h04);
        wr_cmd(8'hC0);
        wr_dat(8'h5A);
        rd_check("t4_rd10", 1'b1, 4'd0, 8'h5A);
        check("t4_cursor", {25'h0, CURSOR_ADDR}, 32'h0F);

        // Decrement from 0x00, then cursor shifts right/left across the wrap
        wr_cmd(8'h80);
        wr_dat(8'h31);
        rd_check("t4b_rd00", 1'b0, 4'd0, 8'h31);
        check("t4b_cursor_dec_wrap", {25'h0, CURSOR_ADDR}, 32'h4F);
        wr_cmd(8'h14);
        check("t4b_shift_right", {25'h0, CURSOR_ADDR}, 32'h00);
        wr_cmd(8'h10);
        check("t4b_shift_left", {25'h0, CURSOR_ADDR}, 32'h4F);
        wr_cmd(8'h18);
        check("t4b_display_shift_ignored", {25'h0, CURSOR_ADDR}, 32'h4F);

        // T5 clear, with a data write landing while busy
        b0 = busy_total; c0 = cv_total;
        pulse_e(1'b0, 1'b0, 8'h01);
        repeat (10) @(negedge CLK);
        pulse_e(1'b1, 1'b0, 8'h58);
        repeat (90) @(negedge CLK);
        check("t5_busy_len", busy_total - b0, 64);
        check("t5_cmd_valid", cv_total - c0, 1);
        check("t5_err", {31'h0, ERR_BUSY_WR}, 32'h1);
        check("t5_cursor", {25'h0, CURSOR_ADDR}, 32'h00);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 16; c++) begin
                rd_check($sformatf("t5_rd%0d_%0d", r, c), r[0], c[3:0], 8'h20);
            end
        end
        // Clear restores increment mode
        wr_dat(8'h33);
        rd_check("t5_rd00_after", 1'b0, 4'd0, 8'h33);
        check("t5_cursor_inc", {25'h0, CURSOR_ADDR}, 32'h01);

        // Instruction read: busy flag / address counter
        wr_cmd(8'hC5);
        b0 = busy_total;
        @(negedge CLK);
        LCD_RS = 1'b0; LCD_RW = 1'b1; LCD_DATA = 8'h00; LCD_E = 1'b1;
        repeat (4) @(negedge CLK);
`ifdef LCD_READBACK_EN
        check("rb_dq_oe", {31'h0, LCD_DQ_OE}, 32'h1);
        check("rb_dq_out", {24'h0, LCD_DQ_OUT}, 32'h45);
`else
        check("rb_dq_oe", {31'h0, LCD_DQ_OE}, 32'h0);
        check("rb_dq_out", {24'h0, LCD_DQ_OUT}, 32'h00);
`endif
        LCD_E = 1'b0;
        repeat (20) @(negedge CLK);
        LCD_RW = 1'b0;
        check("rb_no_busy", busy_total - b0, 0);
        check("rb_cursor", {25'h0, CURSOR_ADDR}, 32'h45);

        // T6 reset during a long busy
        pulse_e(1'b0, 1'b0, 8'h02);
        repeat (10) @(negedge CLK);
        check("t6_busy_before", {31'h0, BUSY}, 32'h1);
        #2 RESETN = 1'b0;
        #1;
        check("t6_busy", {31'h0, BUSY}, 32'h0);
        check("t6_disp_on", {31'h0, DISP_ON}, 32'h0);
        check("t6_err", {31'h0, ERR_BUSY_WR}, 32'h0);
        check("t6_two_line", {31'h0, TWO_LINE}, 32'h0);
        check("t6_cursor", {25'h0, CURSOR_ADDR}, 32'h0);
        check("t6_rd_char", {24'h0, RD_CHAR}, 32'h20);
        @(negedge CLK);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);
        wr_cmd(8'h0C);
        rd_check("t6_rd00", 1'b0, 4'd0, 8'h20);
        rd_check("t6_rd15", 1'b1, 4'd5, 8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
